// File: rtl/id_ex_ctrl_if.sv
// id_ex_ctrl_if
//   Bundles the IF/ID -> decode handshake, the EX flush, and the registered
//   ID/EX control bundle into one interface.
//   master : the surrounding pipeline (drives in_valid, instr, flush, out_ready)
//   slave  : the decode-control stage (drives in_ready, out_valid, bundle)
//   Bundle fields: alufn, jorbranch, branch_type, regwritesrc, memread,
//   memwrite, memtoreg, alusrc, regwrite, memsizesel, mem_unsigned, shamt,
//   rd, rs1, rs2, illegal.
interface id_ex_ctrl_if;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] instr;
    logic        flush;
    logic        out_valid;
    logic        out_ready;
    logic [4:0]  alufn;
    logic [1:0]  jorbranch;
    logic [2:0]  branch_type;
    logic [1:0]  regwritesrc;
    logic        memread;
    logic        memwrite;
    logic        memtoreg;
    logic        alusrc;
    logic        regwrite;
    logic [1:0]  memsizesel;
    logic        mem_unsigned;
    logic [5:0]  shamt;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic        illegal;

    modport master (
        output in_valid, instr, flush, out_ready,
        input  in_ready, out_valid, alufn, jorbranch, branch_type, regwritesrc,
               memread, memwrite, memtoreg, alusrc, regwrite, memsizesel,
               mem_unsigned, shamt, rd, rs1, rs2, illegal
    );

    modport slave (
        input  in_valid, instr, flush, out_ready,
        output in_ready, out_valid, alufn, jorbranch, branch_type, regwritesrc,
               memread, memwrite, memtoreg, alusrc, regwrite, memsizesel,
               mem_unsigned, shamt, rd, rs1, rs2, illegal
    );
endinterface

// File: rtl/id_ex_ctrl.sv
// id_ex_ctrl
//   Decode-control stage between IF/ID and ID/EX. Decodes the presented
//   instruction into a registered control bundle with valid/ready handshake,
//   stalls one bubble on load-use hazards, and drops everything on an EX flush.
//   Optional macro MULDIV_EN: decodes the M extension and throttles issue for
//   DIV_CYCLES cycles after each divide/remainder.
//   Ports: clk, rst_n (async, active low), bus (id_ex_ctrl_if.slave).
//   Parameters: XLEN (32/64, sets shamt width), DIV_CYCLES (2..63).
module id_ex_ctrl #(
    parameter int XLEN       = 32,
    parameter int DIV_CYCLES = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    id_ex_ctrl_if.slave bus
);
    localparam logic [4:0] ALU_ADD  = 5'd0;
    localparam logic [4:0] ALU_SUB  = 5'd1;
    localparam logic [4:0] ALU_SLL  = 5'd2;
    localparam logic [4:0] ALU_SLT  = 5'd3;
    localparam logic [4:0] ALU_SLTU = 5'd4;
    localparam logic [4:0] ALU_XOR  = 5'd5;
    localparam logic [4:0] ALU_SRL  = 5'd6;
    localparam logic [4:0] ALU_SRA  = 5'd7;
    localparam logic [4:0] ALU_OR   = 5'd8;
    localparam logic [4:0] ALU_AND  = 5'd9;
    localparam logic [4:0] ALU_PASS = 5'd10;
    localparam logic [4:0] ALU_MUL  = 5'd11;

    localparam logic [1:0] NO_BRANCH = 2'd0;
    localparam logic [1:0] BRANCH    = 2'd1;
    localparam logic [1:0] JAL       = 2'd2;
    localparam logic [1:0] JALR      = 2'd3;

    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_REG    = 7'b0110011;

    logic [6:0] opcode;
    logic [2:0] funct3;
    logic [6:0] funct7;
    assign opcode = bus.instr[6:0];
    assign funct3 = bus.instr[14:12];
    assign funct7 = bus.instr[31:25];

    logic [4:0] d_alufn;
    logic [1:0] d_jorbranch;
    logic [1:0] d_regwritesrc;
    logic       d_memread, d_memwrite, d_memtoreg, d_alusrc, d_regwrite;
    logic [1:0] d_memsizesel;
    logic       d_unsigned;
    logic [5:0] d_shamt;
    logic       d_illegal;
    logic       d_isdiv;
    logic [5:0] shamt_field;
    logic       shamt_hi_bad;

    // Combinational decode of the presented instruction. Any illegal encoding
    // collapses to a harmless default bundle with only 'illegal' set.
    always_comb begin
        // In RV64 bit 25 is part of shamt; in RV32 it must be zero.
        if (XLEN == 64) begin
            shamt_field  = bus.instr[25:20];
            shamt_hi_bad = bus.instr[31] | (|bus.instr[29:26]);
        end else begin
            shamt_field  = {1'b0, bus.instr[24:20]};
            shamt_hi_bad = bus.instr[31] | (|bus.instr[29:25]);
        end
        d_alufn       = ALU_ADD;
        d_jorbranch   = NO_BRANCH;
        d_regwritesrc = 2'b10;
        d_memread     = 1'b0;
        d_memwrite    = 1'b0;
        d_memtoreg    = 1'b0;
        d_alusrc      = 1'b0;
        d_regwrite    = 1'b0;
        d_memsizesel  = 2'b00;
        d_unsigned    = 1'b0;
        d_shamt       = 6'd0;
        d_illegal     = 1'b0;
        d_isdiv       = 1'b0;
        case (opcode)
            OP_BRANCH: begin
                d_alufn     = ALU_SUB;
                d_jorbranch = BRANCH;
                d_illegal   = (funct3 == 3'b010) || (funct3 == 3'b011);
            end
            OP_LOAD: begin
                d_alusrc   = 1'b1;
                d_memread  = 1'b1;
                d_memtoreg = 1'b1;
                d_regwrite = 1'b1;
                d_unsigned = funct3[2];
                case (funct3)
                    3'b000, 3'b100: d_memsizesel = 2'b01;
                    3'b001, 3'b101: d_memsizesel = 2'b10;
                    3'b010:         d_memsizesel = 2'b00;
                    default:        d_illegal    = 1'b1;
                endcase
            end
            OP_STORE: begin
                d_alusrc   = 1'b1;
                d_memwrite = 1'b1;
                case (funct3)
                    3'b000:  d_memsizesel = 2'b01;
                    3'b001:  d_memsizesel = 2'b10;
                    3'b010:  d_memsizesel = 2'b00;
                    default: d_illegal    = 1'b1;
                endcase
            end
            OP_JAL: begin
                d_jorbranch   = JAL;
                d_regwritesrc = 2'b01;
                d_regwrite    = 1'b1;
            end
            OP_JALR: begin
                d_jorbranch   = JALR;
                d_alusrc      = 1'b1;
                d_regwritesrc = 2'b01;
                d_regwrite    = 1'b1;
                d_illegal     = (funct3 != 3'b000);
            end
            OP_IMM: begin
                d_alusrc   = 1'b1;
                d_regwrite = 1'b1;
                case (funct3)
                    3'b000: d_alufn = ALU_ADD;
                    3'b010: d_alufn = ALU_SLT;
                    3'b011: d_alufn = ALU_SLTU;
                    3'b100: d_alufn = ALU_XOR;
                    3'b110: d_alufn = ALU_OR;
                    3'b111: d_alufn = ALU_AND;
                    3'b001: begin
                        d_alufn   = ALU_SLL;
                        d_shamt   = shamt_field;
                        d_illegal = shamt_hi_bad | bus.instr[30];
                    end
                    default: begin
                        d_alufn   = bus.instr[30] ? ALU_SRA : ALU_SRL;
                        d_shamt   = shamt_field;
                        d_illegal = shamt_hi_bad;
                    end
                endcase
            end
            OP_REG: begin
                d_regwrite = 1'b1;
                case (funct7)
                    7'b0000000: begin
                        case (funct3)
                            3'b000:  d_alufn = ALU_ADD;
                            3'b001:  d_alufn = ALU_SLL;
                            3'b010:  d_alufn = ALU_SLT;
                            3'b011:  d_alufn = ALU_SLTU;
                            3'b100:  d_alufn = ALU_XOR;
                            3'b101:  d_alufn = ALU_SRL;
                            3'b110:  d_alufn = ALU_OR;
                            default: d_alufn = ALU_AND;
                        endcase
                    end
                    7'b0100000: begin
                        if (funct3 == 3'b000)      d_alufn   = ALU_SUB;
                        else if (funct3 == 3'b101) d_alufn   = ALU_SRA;
                        else                       d_illegal = 1'b1;
                    end
`ifdef MULDIV_EN
                    7'b0000001: begin
                        // ALU_MUL..ALU_REMU follow funct3 order
                        d_alufn = ALU_MUL + {2'b00, funct3};
                        d_isdiv = funct3[2];
                    end
`endif
                    default: d_illegal = 1'b1;
                endcase
            end
            OP_AUIPC: begin
                d_alusrc      = 1'b1;
                d_regwrite    = 1'b1;
                d_regwritesrc = 2'b00;
            end
            OP_LUI: begin
                d_alufn    = ALU_PASS;
                d_alusrc   = 1'b1;
                d_regwrite = 1'b1;
            end
            default: d_illegal = 1'b1;
        endcase
        if (d_illegal) begin
            d_alufn       = ALU_ADD;
            d_jorbranch   = NO_BRANCH;
            d_regwritesrc = 2'b10;
            d_memread     = 1'b0;
            d_memwrite    = 1'b0;
            d_memtoreg    = 1'b0;
            d_alusrc      = 1'b0;
            d_regwrite    = 1'b0;
            d_memsizesel  = 2'b00;
            d_unsigned    = 1'b0;
            d_shamt       = 6'd0;
            d_isdiv       = 1'b0;
        end
    end

    logic uses_rs1, uses_rs2, hazard, busy, accept;

    // A valid load in the output register whose destination the incoming
    // instruction reads cannot be forwarded in time: hold it back one cycle.
    assign uses_rs1 = !((opcode == OP_LUI) || (opcode == OP_AUIPC) || (opcode == OP_JAL));
    assign uses_rs2 = (opcode == OP_BRANCH) || (opcode == OP_STORE) || (opcode == OP_REG);
    assign hazard   = bus.out_valid && bus.memread && (bus.rd != 5'd0) &&
                      ((uses_rs1 && (bus.instr[19:15] == bus.rd)) ||
                       (uses_rs2 && (bus.instr[24:20] == bus.rd)));

    assign bus.in_ready = !bus.flush && !busy && (!bus.out_valid || bus.out_ready) && !hazard;
    assign accept       = bus.in_valid && bus.in_ready;

`ifdef MULDIV_EN
    localparam logic [0:0] ST_RUN      = 1'b0;
    localparam logic [0:0] ST_DIV_BUSY = 1'b1;

    logic [0:0] state;
    logic [5:0] div_cnt;

    // Divider occupancy: leaving DIV_BUSY as the count expires lets the next
    // instruction issue exactly DIV_CYCLES edges after the divide.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= ST_RUN;
            div_cnt <= 6'd0;
        end else if (bus.flush) begin
            state   <= ST_RUN;
            div_cnt <= 6'd0;
        end else if (state == ST_RUN) begin
            if (accept && d_isdiv) begin
                state   <= ST_DIV_BUSY;
                div_cnt <= 6'(DIV_CYCLES - 1);
            end
        end else if (div_cnt <= 6'd1) begin
            state   <= ST_RUN;
            div_cnt <= 6'd0;
        end else begin
            div_cnt <= div_cnt - 6'd1;
        end
    end

    assign busy = (state == ST_DIV_BUSY);
`else
    logic div_cycles_unused;
    // Keeps the parameter referenced when the divider is not built.
    assign div_cycles_unused = ^DIV_CYCLES;
    assign busy              = 1'b0;
`endif

    // Output register: flush beats everything, accepted instructions load the
    // whole bundle at once, a consumed bundle without a successor becomes a bubble.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.out_valid    <= 1'b0;
            bus.alufn        <= 5'd0;
            bus.jorbranch    <= 2'd0;
            bus.branch_type  <= 3'd0;
            bus.regwritesrc  <= 2'd0;
            bus.memread      <= 1'b0;
            bus.memwrite     <= 1'b0;
            bus.memtoreg     <= 1'b0;
            bus.alusrc       <= 1'b0;
            bus.regwrite     <= 1'b0;
            bus.memsizesel   <= 2'd0;
            bus.mem_unsigned <= 1'b0;
            bus.shamt        <= 6'd0;
            bus.rd           <= 5'd0;
            bus.rs1          <= 5'd0;
            bus.rs2          <= 5'd0;
            bus.illegal      <= 1'b0;
        end else if (bus.flush) begin
            bus.out_valid <= 1'b0;
        end else if (accept) begin
            bus.out_valid    <= 1'b1;
            bus.alufn        <= d_alufn;
            bus.jorbranch    <= d_jorbranch;
            bus.branch_type  <= funct3;
            bus.regwritesrc  <= d_regwritesrc;
            bus.memread      <= d_memread;
            bus.memwrite     <= d_memwrite;
            bus.memtoreg     <= d_memtoreg;
            bus.alusrc       <= d_alusrc;
            bus.regwrite     <= d_regwrite;
            bus.memsizesel   <= d_memsizesel;
            bus.mem_unsigned <= d_unsigned;
            bus.shamt        <= d_shamt;
            bus.rd           <= bus.instr[11:7];
            bus.rs1          <= bus.instr[19:15];
            bus.rs2          <= bus.instr[24:20];
            bus.illegal      <= d_illegal;
        end else if (bus.out_ready) begin
            bus.out_valid <= 1'b0;
        end
    end
endmodule

// File: tb/tb_id_ex_ctrl.sv
`timescale 1ns/1ps
module tb_id_ex_ctrl;
    localparam int XLEN       = 32;
    localparam int DIV_CYCLES = 8;

    localparam logic [4:0] A_ADD  = 5'd0;
    localparam logic [4:0] A_SUB  = 5'd1;
    localparam logic [4:0] A_SLL  = 5'd2;
    localparam logic [4:0] A_SLT  = 5'd3;
    localparam logic [4:0] A_SLTU = 5'd4;
    localparam logic [4:0] A_XOR  = 5'd5;
    localparam logic [4:0] A_SRL  = 5'd6;
    localparam logic [4:0] A_SRA  = 5'd7;
    localparam logic [4:0] A_OR   = 5'd8;
    localparam logic [4:0] A_AND  = 5'd9;
    localparam logic [4:0] A_PASS = 5'd10;
    localparam logic [4:0] A_MUL  = 5'd11;
    localparam logic [4:0] A_DIV  = 5'd15;

    typedef struct packed {
        logic [4:0] alufn;
        logic [1:0] jorbranch;
        logic [2:0] branch_type;
        logic [1:0] regwritesrc;
        logic       memread;
        logic       memwrite;
        logic       memtoreg;
        logic       alusrc;
        logic       regwrite;
        logic [1:0] memsizesel;
        logic       mem_unsigned;
        logic [5:0] shamt;
        logic [4:0] rd;
        logic [4:0] rs1;
        logic [4:0] rs2;
        logic       illegal;
    } bundle_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   total = 0;
    int   bad   = 0;

    id_ex_ctrl_if bus();

    id_ex_ctrl #(.XLEN(XLEN), .DIV_CYCLES(DIV_CYCLES)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // One comparison: counts it, reports a FAIL line on disagreement.
    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, actual, expected, $time);
        end
    endtask

    // Drives one cycle of inputs shortly after the rising edge.
    task automatic applyStimulus(input logic v, input logic [31:0] i, input logic f, input logic r);
        @(posedge clk);
        #1;
        bus.in_valid  = v;
        bus.instr     = i;
        bus.flush     = f;
        bus.out_ready = r;
    endtask

    function automatic bundle_t dut_bundle();
        bundle_t b;
        b.alufn        = bus.alufn;
        b.jorbranch    = bus.jorbranch;
        b.branch_type  = bus.branch_type;
        b.regwritesrc  = bus.regwritesrc;
        b.memread      = bus.memread;
        b.memwrite     = bus.memwrite;
        b.memtoreg     = bus.memtoreg;
        b.alusrc       = bus.alusrc;
        b.regwrite     = bus.regwrite;
        b.memsizesel   = bus.memsizesel;
        b.mem_unsigned = bus.mem_unsigned;
        b.shamt        = bus.shamt;
        b.rd           = bus.rd;
        b.rs1          = bus.rs1;
        b.rs2          = bus.rs2;
        b.illegal      = bus.illegal;
        return b;
    endfunction

    function automatic logic [4:0] base_op(input logic [2:0] f3);
        case (f3)
            3'd0:    return A_ADD;
            3'd1:    return A_SLL;
            3'd2:    return A_SLT;
            3'd3:    return A_SLTU;
            3'd4:    return A_XOR;
            3'd5:    return A_SRL;
            3'd6:    return A_OR;
            default: return A_AND;
        endcase
    endfunction

    function automatic logic [1:0] size_code(input logic [1:0] s);
        if (s == 2'd0) return 2'b01;
        if (s == 2'd1) return 2'b10;
        return 2'b00;
    endfunction

    // Reference decode, derived from the instruction-class rules.
    function automatic bundle_t model_decode(input logic [31:0] i);
        bundle_t b;
        logic [2:0] f3;
        logic [6:0] f7;
        logic ok;
        int lg, imm12, upper;
        b = '0;
        f3 = i[14:12];
        f7 = i[31:25];
        ok = 1'b1;
        b.branch_type = f3;
        b.rd = i[11:7];
        b.rs1 = i[19:15];
        b.rs2 = i[24:20];
        b.alufn = A_ADD;
        b.regwritesrc = 2'b10;
        case (i[6:0])
            7'h37: begin b.alufn = A_PASS; b.alusrc = 1; b.regwrite = 1; end
            7'h17: begin b.alusrc = 1; b.regwrite = 1; b.regwritesrc = 2'b00; end
            7'h6f: begin b.jorbranch = 2'd2; b.regwritesrc = 2'b01; b.regwrite = 1; end
            7'h67: begin
                ok = (f3 == 0);
                b.jorbranch = 2'd3; b.alusrc = 1; b.regwritesrc = 2'b01; b.regwrite = 1;
            end
            7'h63: begin ok = (f3 != 2) && (f3 != 3); b.alufn = A_SUB; b.jorbranch = 2'd1; end
            7'h03: begin
                ok = (f3 != 3) && (f3 < 6);
                b.memread = 1; b.memtoreg = 1; b.regwrite = 1; b.alusrc = 1;
                b.memsizesel = size_code(f3[1:0]); b.mem_unsigned = f3[2];
            end
            7'h23: begin ok = (f3 <= 2); b.memwrite = 1; b.alusrc = 1; b.memsizesel = size_code(f3[1:0]); end
            7'h13: begin
                b.alusrc = 1; b.regwrite = 1;
                b.alufn = base_op(f3);
                if (f3 == 1 || f3 == 5) begin
                    lg    = (XLEN == 64) ? 6 : 5;
                    imm12 = int'(i[31:20]);
                    upper = imm12 >> lg;
                    ok = (upper == 0) || (f3 == 5 && upper == (1 << (10 - lg)));
                    if (upper != 0) b.alufn = A_SRA;
                    b.shamt = 6'(imm12 & (XLEN - 1));
                end
            end
            7'h33: begin
                b.regwrite = 1;
                if (f7 == 7'h00) b.alufn = base_op(f3);
                else if (f7 == 7'h20) begin
                    ok = (f3 == 0) || (f3 == 5);
                    b.alufn = (f3 == 0) ? A_SUB : A_SRA;
                end else if (f7 == 7'h01) begin
`ifdef MULDIV_EN
                    b.alufn = A_MUL + 5'(f3);
`else
                    ok = 1'b0;
`endif
                end else ok = 1'b0;
            end
            default: ok = 1'b0;
        endcase
        if (!ok) begin
            b = '0;
            b.branch_type = f3;
            b.rd = i[11:7];
            b.rs1 = i[19:15];
            b.rs2 = i[24:20];
            b.alufn = A_ADD;
            b.regwritesrc = 2'b10;
            b.illegal = 1'b1;
        end
        return b;
    endfunction

    function automatic bit model_is_div(input logic [31:0] i);
`ifdef MULDIV_EN
        return (i[6:0] == 7'h33) && (i[31:25] == 7'h01) && i[14];
`else
        return (i[6:0] == 7'h7f) && 1'b0;
`endif
    endfunction

    // Model state: expected output register and the first cycle at which
    // issue is allowed again after a divide.
    logic    m_valid   = 1'b0;
    bundle_t m_b       = '0;
    int      m_cyc     = 0;
    int      m_free_at = 0;
    logic    exp_ready;
    logic    m_src1, m_src2, m_hazard;

    // Mid-cycle compare against the model, then advance the model by one edge.
    always @(negedge clk) begin
        if (!rst_n) begin
            m_valid   = 1'b0;
            m_free_at = 0;
            m_cyc     = 0;
        end else begin
            checkOutput("out_valid", bus.out_valid, m_valid);
            if (m_valid) checkOutput("bundle", dut_bundle(), m_b);
            m_src1   = !(bus.instr[6:0] inside {7'h37, 7'h17, 7'h6f});
            m_src2   = bus.instr[6:0] inside {7'h63, 7'h23, 7'h33};
            m_hazard = m_valid && m_b.memread && (m_b.rd != 0) &&
                       ((m_src1 && bus.instr[19:15] == m_b.rd) || (m_src2 && bus.instr[24:20] == m_b.rd));
            exp_ready = !bus.flush && (m_cyc >= m_free_at) && (!m_valid || bus.out_ready) && !m_hazard;
            checkOutput("in_ready", bus.in_ready, exp_ready);
            if (bus.flush) begin
                m_valid   = 1'b0;
                m_free_at = 0;
            end else if (bus.in_valid && exp_ready) begin
                m_valid = 1'b1;
                m_b     = model_decode(bus.instr);
                if (model_is_div(bus.instr)) m_free_at = m_cyc + DIV_CYCLES;
            end else if (bus.out_ready) begin
                m_valid = 1'b0;
            end
            m_cyc++;
        end
    end

    function automatic logic [31:0] gen_instr();
        logic [31:0] h;
        logic [4:0]  rd, r1, r2;
        logic [2:0]  f3;
        logic [6:0]  f7;
        h  = $urandom;
        rd = 5'($urandom_range(0, 3));
        r1 = 5'($urandom_range(0, 3));
        r2 = 5'($urandom_range(0, 3));
        f3 = 3'($urandom_range(0, 7));
        case ($urandom_range(0, 3))
            0:       f7 = 7'h00;
            1:       f7 = 7'h20;
            2:       f7 = 7'h01;
            default: f7 = h[31:25];
        endcase
        case ($urandom_range(0, 10))
            0:       return {h[31:12], rd, 7'h37};
            1:       return {h[31:12], rd, 7'h17};
            2:       return {h[31:12], rd, 7'h6f};
            3:       return {h[31:20], r1, (h[0] ? f3 : 3'd0), rd, 7'h67};
            4:       return {h[31:25], r2, r1, f3, h[11:7], 7'h63};
            5:       return {h[31:20], r1, f3, rd, 7'h03};
            6:       return {h[31:25], r2, r1, f3, h[11:7], 7'h23};
            7:       return {(h[1] ? f7 : 7'h00), h[24:20], r1, f3, rd, 7'h13};
            8:       return {f7, r2, r1, f3, rd, 7'h33};
            9:       return {7'h01, r2, r1, 1'b1, f3[1:0], rd, 7'h33};
            default: return h;
        endcase
    endfunction

    initial begin
        bus.in_valid  = 1'b0;
        bus.instr     = 32'h0;
        bus.flush     = 1'b0;
        bus.out_ready = 1'b1;

        // Reset held with an instruction presented: bundle stays cleared.
        applyStimulus(1, 32'h00A00093, 0, 1);
        @(negedge clk);
        checkOutput("rst_valid", bus.out_valid, 0);
        checkOutput("rst_bundle", dut_bundle(), 0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        applyStimulus(0, 32'h0, 0, 1);
        @(negedge clk);
        checkOutput("addi_valid", bus.out_valid, 1);
        checkOutput("addi_alufn", bus.alufn, A_ADD);
        checkOutput("addi_alusrc", bus.alusrc, 1);
        checkOutput("addi_regwrite", bus.regwrite, 1);
        checkOutput("addi_rd", bus.rd, 1);

        // Load-use: lw x5 then add x6,x5,x1 gets one bubble.
        applyStimulus(1, 32'h00012283, 0, 1);
        applyStimulus(1, 32'h00128333, 0, 1);
        @(negedge clk);
        checkOutput("lu_stall_ready", bus.in_ready, 0);
        checkOutput("lu_load_memread", bus.memread, 1);
        applyStimulus(1, 32'h00128333, 0, 1);
        @(negedge clk);
        checkOutput("lu_bubble", bus.out_valid, 0);
        checkOutput("lu_ready_again", bus.in_ready, 1);
        applyStimulus(0, 32'h0, 0, 1);
        @(negedge clk);
        checkOutput("lu_add_valid", bus.out_valid, 1);
        checkOutput("lu_add_rs1", bus.rs1, 5);
        checkOutput("lu_add_rd", bus.rd, 6);

        // Load to x0 never stalls.
        applyStimulus(1, 32'h00012003, 0, 1);
        applyStimulus(1, 32'h00100333, 0, 1);
        @(negedge clk);
        checkOutput("x0_no_stall", bus.in_ready, 1);
        applyStimulus(0, 32'h0, 0, 1);
        @(negedge clk);
        checkOutput("x0_add_rd", bus.rd, 6);

        // Flush with a stalled bundle and a presented instruction.
        applyStimulus(1, 32'h00A00093, 0, 0);
        applyStimulus(1, 32'h00200113, 1, 0);
        @(negedge clk);
        checkOutput("fl_ready", bus.in_ready, 0);
        applyStimulus(1, 32'h00300193, 0, 1);
        @(negedge clk);
        checkOutput("fl_killed", bus.out_valid, 0);
        checkOutput("fl_ready_after", bus.in_ready, 1);
        applyStimulus(0, 32'h0, 0, 1);
        @(negedge clk);
        checkOutput("fl_next_rd", bus.rd, 3);

`ifdef MULDIV_EN
        // Divide blocks issue for DIV_CYCLES-1 cycles.
        applyStimulus(1, 32'h0262C3B3, 0, 1);
        for (int k = 1; k <= DIV_CYCLES; k++) begin
            applyStimulus(1, 32'h00300193, 0, 1);
            @(negedge clk);
            if (k == 1) checkOutput("div_alufn", bus.alufn, A_DIV);
            checkOutput("div_ready", bus.in_ready, (k == DIV_CYCLES));
        end
        applyStimulus(1, 32'h0262C3B3, 0, 1);
        applyStimulus(1, 32'h00300193, 0, 1);
        @(negedge clk);
        checkOutput("divf_busy", bus.in_ready, 0);
        applyStimulus(1, 32'h00300193, 1, 1);
        applyStimulus(1, 32'h00300193, 0, 1);
        @(negedge clk);
        checkOutput("divf_ready", bus.in_ready, 1);
`else
        applyStimulus(1, 32'h0262C3B3, 0, 1);
        applyStimulus(1, 32'h0000007F, 0, 1);
        @(negedge clk);
        checkOutput("mdiv_illegal", bus.illegal, 1);
        checkOutput("mdiv_regwrite", bus.regwrite, 0);
        applyStimulus(0, 32'h0, 0, 1);
        @(negedge clk);
        checkOutput("op7f_illegal", bus.illegal, 1);
`endif

        // slli x1,x1,40: legal only with 64-bit shamt.
        applyStimulus(1, 32'h02809093, 0, 1);
        applyStimulus(0, 32'h0, 0, 1);
        @(negedge clk);
        checkOutput("slli40_illegal", bus.illegal, (XLEN == 32));
        checkOutput("slli40_shamt", bus.shamt, (XLEN == 64) ? 40 : 0);

        // Randomized traffic with flushes, backpressure and one reset pulse.
        for (int n = 0; n < 3000; n++) begin
            applyStimulus(($urandom_range(0, 3) != 0), gen_instr(),
                          ($urandom_range(0, 24) == 0), ($urandom_range(0, 3) != 0));
            if (n == 1500) begin
                #2 rst_n = 1'b0;
                @(posedge clk);
                #1 rst_n = 1'b1;
            end
        end
        applyStimulus(0, 32'h0, 0, 1);
        @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
